// File: rtl/mem_arb_pkg.sv
// Shared helpers for the memory arbiter: address width derivation,
// one-hot decoding and round-robin pointer advance.
package mem_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_advance(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: owns the priority pointer and the rotate/priority
// scan. Grant is combinational and forced low while rst_n is low.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [IDX_W-1:0]   ptr;
    logic [MAX_REQ-1:0] grant_ext;

    always_comb begin
        int  j;
        logic found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
                if (!found && req[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    assign grant_ext = MAX_REQ'(grant);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= ptr_advance(onehot_to_idx(grant_ext), N);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one simple-dual-port RAM between N_REQ requesters with independent
// round-robin read and write arbitration. MEM_ARB_FORWARD_EN adds write->read forwarding.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        rd_valid,
    input  logic [N_REQ*ADDR_W-1:0] rd_addr,
    output logic [N_REQ-1:0]        rd_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    input  logic [N_REQ-1:0]        wr_valid,
    input  logic [N_REQ*ADDR_W-1:0] wr_addr,
    input  logic [N_REQ*WIDTH-1:0]  wr_data,
    output logic [N_REQ-1:0]        wr_ready,
    output logic [ADDR_W-1:0]       mem_rdaddress,
    output logic [ADDR_W-1:0]       mem_wraddress,
    output logic [WIDTH-1:0]        mem_data,
    output logic                    mem_wren,
    input  logic [WIDTH-1:0]        mem_q
);

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              rd_any;
    logic              wr_any;
    logic [ADDR_W-1:0] rd_sel_addr;
    logic [ADDR_W-1:0] wr_sel_addr;
    logic [WIDTH-1:0]  wr_sel_data;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic [N_REQ-1:0]  tag;

    rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clock (clock),
        .rst_n (rst_n),
        .req   (rd_valid),
        .grant (rd_ready)
    );

    rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clock (clock),
        .rst_n (rst_n),
        .req   (wr_valid),
        .grant (wr_ready)
    );

    assign rd_any = |rd_ready;
    assign wr_any = |wr_ready;
    assign rd_idx = onehot_to_idx(MAX_REQ'(rd_ready));
    assign wr_idx = onehot_to_idx(MAX_REQ'(wr_ready));

    assign rd_sel_addr = rd_addr[int'(rd_idx)*ADDR_W +: ADDR_W];
    assign wr_sel_addr = wr_addr[int'(wr_idx)*ADDR_W +: ADDR_W];
    assign wr_sel_data = wr_data[int'(wr_idx)*WIDTH +: WIDTH];

    // Ports drive the granted request this cycle; otherwise they hold the
    // last granted values so the memory inputs do not toggle when idle.
    assign mem_rdaddress = rd_any ? rd_sel_addr : rd_addr_q;
    assign mem_wraddress = wr_any ? wr_sel_addr : wr_addr_q;
    assign mem_data      = wr_any ? wr_sel_data : wr_data_q;
    assign mem_wren      = wr_any;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tag       <= '0;
        end else begin
            if (rd_any) rd_addr_q <= rd_sel_addr;
            if (wr_any) begin
                wr_addr_q <= wr_sel_addr;
                wr_data_q <= wr_sel_data;
            end
            tag <= rd_ready;
        end
    end

    assign rsp_valid = tag;

`ifdef MEM_ARB_FORWARD_EN
    logic             fwd_hit;
    logic             fwd_sel_q;
    logic [WIDTH-1:0] fwd_data_q;

    assign fwd_hit = rd_any && wr_any && (rd_sel_addr == wr_sel_addr);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q <= fwd_hit;
            if (fwd_hit) fwd_data_q <= wr_sel_data;
        end
    end

    assign rsp_data = fwd_sel_q ? fwd_data_q : mem_q;
`else
    assign rsp_data = mem_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-first RAM, a
// round-robin reference model and a response scoreboard queue.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 512;
    localparam int AW = 9;

    logic            clock = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    rd_valid = '0;
    logic [N*AW-1:0] rd_addr = '0;
    logic [N-1:0]    rd_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic [N-1:0]    wr_valid = '0;
    logic [N*AW-1:0] wr_addr = '0;
    logic [N*W-1:0]  wr_data = '0;
    logic [N-1:0]    wr_ready;
    logic [AW-1:0]   mem_rdaddress;
    logic [AW-1:0]   mem_wraddress;
    logic [W-1:0]    mem_data;
    logic            mem_wren;
    logic [W-1:0]    mem_q;

    mem_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_ready      (rd_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .mem_rdaddress (mem_rdaddress),
        .mem_wraddress (mem_wraddress),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
    );

    always #5 clock = ~clock;

    // Read-first simple-dual-port RAM with registered output
    logic [W-1:0] ram [D];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_wraddress] <= mem_data;
        mem_q <= ram[mem_rdaddress];
    end

    typedef struct packed {
        logic [N-1:0] vld;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t         sb[$];
    logic [W-1:0] ref_mem [D];
    int           vectors = 0;
    int           miscompares = 0;
    int           rd_ptr_m = 0;
    int           wr_ptr_m = 0;

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (req[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check grants against the model, push the expected response,
    // then pop and compare it after the clock edge.
    task automatic tick(input string tag);
        logic [N-1:0]  er;
        logic [N-1:0]  ew;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        int            ri;
        int            wi;
        rsp_t          e;
        #3;
        er = rst_n ? rr_pick(rd_valid, rd_ptr_m) : '0;
        ew = rst_n ? rr_pick(wr_valid, wr_ptr_m) : '0;
        chk({tag, ".rd_ready"}, 32'(rd_ready), 32'(er));
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(ew));
        chk({tag, ".mem_wren"}, 32'(mem_wren), 32'(|ew));
        e.vld  = er;
        e.data = '0;
        ra     = '0;
        if (er != 0) begin
            ri = oh_idx(er);
            ra = rd_addr[ri*AW +: AW];
            chk({tag, ".mem_rdaddress"}, 32'(mem_rdaddress), 32'(ra));
            e.data = ref_mem[ra];
            rd_ptr_m = (ri + 1) % N;
        end
        if (ew != 0) begin
            wi = oh_idx(ew);
            wa = wr_addr[wi*AW +: AW];
            wd = wr_data[wi*W +: W];
            chk({tag, ".mem_wraddress"}, 32'(mem_wraddress), 32'(wa));
            chk({tag, ".mem_data"}, 32'(mem_data), 32'(wd));
`ifdef MEM_ARB_FORWARD_EN
            if (er != 0 && ra == wa) e.data = wd;
`endif
            ref_mem[wa] = wd;
            wr_ptr_m = (wi + 1) % N;
        end
        if (!rst_n) begin
            rd_ptr_m = 0;
            wr_ptr_m = 0;
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(e.vld));
        if (e.vld != 0) chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(e.data));
    endtask

    initial begin
        for (int a = 0; a < D; a++) begin
            ram[a]     = '0;
            ref_mem[a] = '0;
        end
        @(posedge clock);
        #1;

        // Reset held with every requester asking
        rst_n    = 1'b0;
        rd_valid = '1;
        wr_valid = '1;
        repeat (2) tick("reset");
        chk("reset.mem_rdaddress", 32'(mem_rdaddress), 32'd0);
        chk("reset.mem_wraddress", 32'(mem_wraddress), 32'd0);
        rst_n    = 1'b1;
        rd_valid = '0;
        wr_valid = '0;

        // Requester 2 writes 0xA5 to address 7, requester 1 reads it back
        wr_addr[2*AW +: AW] = 9'd7;
        wr_data[2*W +: W]   = 8'hA5;
        wr_valid = 4'b0100;
        tick("wr_a5");
        wr_valid = '0;
        rd_addr[1*AW +: AW] = 9'd7;
        rd_valid = 4'b0010;
        tick("single_rd");
        chk("single_rd.rsp_valid_lit", 32'(rsp_valid), 32'b0010);
        chk("single_rd.rsp_data_lit", 32'(rsp_data), 32'hA5);
        rd_valid = '0;

        // Re-centre both pointers, then all readers contend
        rst_n = 1'b0;
        tick("ptr_clr");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = AW'(7 + i);
        rd_valid = '1;
        repeat (8) tick("fair");

        // Pointer lands on 1, then only 0 and 3 request
        rd_valid = 4'b0001;
        tick("skip_pre");
        rd_valid = 4'b1001;
        repeat (3) tick("skip");
        rd_valid = '0;

        // Same-address read and write in one cycle
        wr_addr[0*AW +: AW] = 9'd5;
        wr_data[0*W +: W]   = 8'h11;
        wr_valid = 4'b0001;
        tick("rw_init");
        wr_data[0*W +: W]   = 8'h3C;
        rd_addr[1*AW +: AW] = 9'd5;
        rd_valid = 4'b0010;
        tick("rw_same");
        wr_valid = '0;
        tick("rw_next");
        chk("rw_next.rsp_data_lit", 32'(rsp_data), 32'h3C);
        rd_valid = '0;

        // Reset in the cycle after a read grant
        rd_addr[2*AW +: AW] = 9'd5;
        rd_valid = 4'b0100;
        tick("pre_rst");
        rst_n    = 1'b0;
        rd_valid = '1;
        wr_valid = '1;
        repeat (2) tick("in_rst");
        rst_n    = 1'b1;
        wr_valid = '0;
        tick("post_rst");
        chk("post_rst.first_grant", 32'(rsp_valid), 32'b0001);
        rd_valid = '0;

        // All writers contend, each writing its own ID
        for (int i = 0; i < N; i++) begin
            wr_addr[i*AW +: AW] = AW'(9'h100 + i);
            wr_data[i*W +: W]   = W'(i);
        end
        wr_valid = '1;
        repeat (4) tick("wr_all");
        wr_valid = '0;
        for (int i = 0; i < N; i++) begin
            rd_addr[0*AW +: AW] = AW'(9'h100 + i);
            rd_valid = 4'b0001;
            tick("readback");
            chk("readback.id", 32'(rsp_data), 32'(i));
        end
        rd_valid = '0;
        tick("idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
